// File: rtl/disp_scan_ctrl_if.sv
// Signal bundle between the display scan controller and its reading sources / display mux.
// The master drives readings and the mode pulse; the slave is the controller.
interface disp_scan_ctrl_if;
  // No handshake: readings are levels sampled at frame boundaries, Btn_Mode is a
  // single-cycle pulse counted on every clock, all outputs are free-running.
  logic [15:0] Frec_Val;
  logic [15:0] Co_Val;
  logic        Btn_Mode;
  logic        Sel;
  logic [3:0]  En_Frec;
  logic [3:0]  En_Co;
  logic [3:0]  An;
  logic        Frame;
  logic        scan_state;  // debug view of the slot FSM: 0 = BLANK, 1 = ON

  modport master (
    output Frec_Val, Co_Val, Btn_Mode,
    input  Sel, En_Frec, En_Co, An, Frame, scan_state
  );

  modport slave (
    input  Frec_Val, Co_Val, Btn_Mode,
    output Sel, En_Frec, En_Co, An, Frame, scan_state
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// 4-digit 7-segment scan controller with frame-aligned snapshots and source select.
// Optional leading-zero blanking is compiled in when DISP_LZB_EN is defined.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             reset_n,
  disp_scan_ctrl_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [1:0]    digit, digit_nx;
  logic          slot_end;
  logic          frame_end;
  logic          mode_pend;
  logic          sel;
  logic          frame;
  logic [15:0]   snap_frec;
  logic [15:0]   snap_co;
  logic          digit_lit;
  logic [3:0]    an;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BLANK;
      presc <= '0;
      digit <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      digit <= digit_nx;
    end
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc + 1'b1;
    digit_nx = digit;
    slot_end = 1'b0;
    case (state)
      BLANK: if (presc == BLANK_LAST) state_nx = ON;
      ON: begin
        if (presc == SCAN_LAST) begin
          state_nx = BLANK;
          presc_nx = '0;
          digit_nx = digit + 2'd1;
          slot_end = 1'b1;
        end
      end
      default: state_nx = BLANK;
    endcase
  end

  assign frame_end = slot_end && (digit == 2'd3);

  // A pulse on the boundary edge is folded into the Sel update of that same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_pend <= 1'b0;
      sel       <= 1'b0;
      frame     <= 1'b0;
      snap_frec <= '0;
      snap_co   <= '0;
    end else begin
      mode_pend <= mode_pend ^ bus.Btn_Mode;
      frame     <= frame_end;
      if (frame_end) begin
        sel       <= mode_pend ^ bus.Btn_Mode;
        snap_frec <= bus.Frec_Val;
        snap_co   <= bus.Co_Val;
      end
    end
  end

`ifdef DISP_LZB_EN
  logic [15:0] shown;
  assign shown = sel ? snap_co : snap_frec;

  // Digit d goes dark when it and every more significant nibble are zero.
  always_comb begin
    digit_lit = 1'b1;
    case (digit)
      2'd1:    digit_lit = |shown[15:4];
      2'd2:    digit_lit = |shown[15:8];
      2'd3:    digit_lit = |shown[15:12];
      default: digit_lit = 1'b1;
    endcase
  end
`else
  assign digit_lit = 1'b1;
`endif

  always_comb begin
    an = 4'b1111;
    if (state == ON && digit_lit) an = ~(4'b0001 << digit);
  end

  assign bus.An         = an;
  assign bus.Sel        = sel;
  assign bus.Frame      = frame;
  assign bus.En_Frec    = snap_frec[4*digit +: 4];
  assign bus.En_Co      = snap_co[4*digit +: 4];
  assign bus.scan_state = state;

endmodule
